// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Op codes and helpers shared by the multiply/divide unit.
//               MDU_* codes live in 8'h40..8'h45, a range the ALU_* codes
//               never use, so one 8-bit operation bus can serve both units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    localparam logic [7:0] MDU_mult  = 8'h40;
    localparam logic [7:0] MDU_multu = 8'h41;
    localparam logic [7:0] MDU_div   = 8'h42;
    localparam logic [7:0] MDU_divu  = 8'h43;
    localparam logic [7:0] MDU_mthi  = 8'h44;
    localparam logic [7:0] MDU_mtlo  = 8'h45;

    localparam int unsigned C_WIDTH = 32;
    localparam int unsigned C_ITERS = 32;

    // True for the op codes that launch the iterative datapath.
    function automatic logic is_muldiv(input logic [7:0] op);
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_div)  || (op == MDU_divu);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == MDU_mult) || (op == MDU_div);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage : muldiv_unit_pkg

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle radix-2 multiply/divide unit owning HI/LO.
//               MULT/MULTU: shift-add, LSB-first, 32 iterations.
//               DIV/DIVU  : restoring division, MSB-first, 32 iterations.
//               A FIX cycle applies sign correction and writes HI/LO.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous reset, active low
//               start     - issue strobe, sampled only in IDLE
//               operation - MDU_* op code
//               A, B      - rs / rt operands
//               hi, lo    - HI / LO registers
//               busy      - operation in flight (33 cycles)
//               done      - one-cycle pulse when a MULT/DIV result lands
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  operation,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_cnt;
    logic [63:0] r_acc;      // {upper/remainder, lower/quotient}
    logic [31:0] r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [31:0] r_a_orig;   // untouched A, returned as HI on divide-by-zero
    logic [7:0]  r_op;
    logic        r_neg_a;
    logic        r_neg_b;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start && is_muldiv(operation)) w_next_state = ST_CALC;
            ST_CALC: if (r_cnt == 6'(C_ITERS - 1))       w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    logic        w_sgn;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign w_sgn   = is_signed_op(operation);
    assign w_neg_a = w_sgn & A[31];
    assign w_neg_b = w_sgn & B[31];
    assign w_mag_a = w_neg_a ? (~A + 32'd1) : A;
    assign w_mag_b = w_neg_b ? (~B + 32'd1) : B;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole thing right.
    logic [32:0] w_add;
    logic [63:0] w_mul_next;

    assign w_add      = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_add, r_acc[31:1]}
                                 : {1'b0, r_acc[63:32], r_acc[31:1]};

    // Divide: shift left one, trial-subtract the divisor from the 33-bit
    // partial remainder. If the shifted remainder spilled into bit 32 it is
    // certainly >= divisor, so only the low 32 bits need the subtractor.
    logic [32:0] w_rem_sh;
    logic [32:0] w_sub;
    logic        w_ge;
    logic [63:0] w_div_next;

    assign w_rem_sh   = r_acc[63:31];
    assign w_sub      = {1'b0, w_rem_sh[31:0]} - {1'b0, r_opnd};
    assign w_ge       = w_rem_sh[32] | ~w_sub[32];
    assign w_div_next = w_ge ? {w_sub[31:0],     r_acc[30:0], 1'b1}
                             : {w_rem_sh[31:0],  r_acc[30:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic [63:0] w_prod_neg;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_prod_neg = ~r_acc + 64'd1;
    assign w_quo      = (r_neg_a ^ r_neg_b) ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0];
    assign w_rem      = r_neg_a             ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_fix_hi = r_acc[63:32];
        w_fix_lo = r_acc[31:0];
        if (is_div_op(r_op)) begin
            if (r_div0) begin
                w_fix_hi = r_a_orig;
                w_fix_lo = 32'hFFFF_FFFF;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
        end else if (r_neg_a ^ r_neg_b) begin
            // Sign flags can only differ for signed MULT.
            w_fix_hi = w_prod_neg[63:32];
            w_fix_lo = w_prod_neg[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_a_orig <= 32'd0;
            r_op     <= 8'd0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (operation == MDU_mthi) begin
                            r_hi <= A;
                        end else if (operation == MDU_mtlo) begin
                            r_lo <= A;
                        end else if (is_muldiv(operation)) begin
                            r_op     <= operation;
                            r_neg_a  <= w_neg_a;
                            r_neg_b  <= w_neg_b;
                            r_a_orig <= A;
                            r_div0   <= (B == 32'd0);
                            r_cnt    <= 6'd0;
                            if (is_div_op(operation)) begin
                                r_acc  <= {32'd0, w_mag_a};
                                r_opnd <= w_mag_b;
                            end else begin
                                r_acc  <= {32'd0, w_mag_b};
                                r_opnd <= w_mag_a;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= is_div_op(r_op) ? w_div_next : w_mul_next;
                end
                ST_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule : muldiv_unit

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. A table of MULT/DIV
//               vectors with hand-computed HI/LO, plus directed sequences
//               for MTHI/MTLO, ignored issues and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  operation = 8'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operation (operation),
        .A         (A),
        .B         (B),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int N_VEC = 10;
    vec_t vecs [N_VEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a one-cycle start strobe across one rising edge.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        operation = op;
        A         = a;
        B         = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issue a MULT/DIV-class op and observe 40 cycles: busy cycles, done
    // pulses, and whether HI/LO stayed put while busy.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cnt, output logic hold_ok,
                          output logic done_sync);
        logic [31:0] hi0, lo0;
        hi0       = hi;
        lo0       = lo;
        busy_cyc  = 0;
        done_cnt  = 0;
        hold_ok   = 1'b1;
        done_sync = 1'b1;
        issue(op, a, b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cyc++;
                if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (busy) done_sync = 1'b0;
            end
        end
    endtask

    initial begin
        int   bc, dc;
        logic hok, dsync;

        vecs[0] = '{MDU_mult,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{MDU_multu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{MDU_div,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MDU_divu,  32'd7,          32'd2,         32'd1,         32'd3};
        vecs[4] = '{MDU_divu,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[5] = '{MDU_div,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6] = '{MDU_div,   32'd100,        32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2};
        vecs[7] = '{MDU_mult,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[8] = '{MDU_div,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9] = '{MDU_multu, 32'h0001_0000,  32'h0001_0000, 32'd1,         32'd0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hi",   hi,            32'd0);
        chk("reset_lo",   lo,            32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b1;

        // Table-driven MULT/DIV vectors
        for (int v = 0; v < N_VEC; v++) begin
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, bc, dc, hok, dsync);
            chk($sformatf("vec%0d_hi", v),    hi,              vecs[v].exp_hi);
            chk($sformatf("vec%0d_lo", v),    lo,              vecs[v].exp_lo);
            chk($sformatf("vec%0d_busy_cycles", v), 32'(bc),   32'd33);
            chk($sformatf("vec%0d_done_pulses", v), 32'(dc),   32'd1);
            chk($sformatf("vec%0d_hold", v),  {31'd0, hok},    32'd1);
            chk($sformatf("vec%0d_done_after_busy", v), {31'd0, dsync}, 32'd1);
        end

        // MTHI in IDLE: visible next cycle, no busy, no done
        issue(MDU_mthi, 32'h1234_5678, 32'd0);
        @(negedge clk);
        chk("mthi_hi",   hi,            32'h1234_5678);
        chk("mthi_lo",   lo,            32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);

        issue(MDU_mtlo, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        chk("mtlo_lo",   lo,            32'hCAFE_F00D);
        chk("mtlo_hi",   hi,            32'h1234_5678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // Unknown op code is ignored
        issue(8'hFF, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        chk("badop_busy", {31'd0, busy}, 32'd0);
        chk("badop_hi",   hi,            32'h1234_5678);
        chk("badop_lo",   lo,            32'hCAFE_F00D);

        // MTLO while busy is ignored; DIVU 7/2 result lands
        issue(MDU_divu, 32'd7, 32'd2);
        repeat (4) @(negedge clk);
        start = 1'b1; operation = MDU_mtlo; A = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("mtlo_busy_ignored_now", lo, 32'hCAFE_F00D);
        begin
            int guard = 0;
            while (busy && guard < 60) begin
                @(negedge clk);
                guard++;
            end
            chk("mtlo_busy_timeout", {31'd0, busy}, 32'd0);
        end
        chk("mtlo_busy_final_lo", lo, 32'd3);
        chk("mtlo_busy_final_hi", hi, 32'd1);

        // Reset in the middle of a MULT
        issue(MDU_mult, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_hi",   hi,            32'd0);
        chk("midrst_lo",   lo,            32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(MDU_multu, 32'd3, 32'd4, bc, dc, hok, dsync);
        chk("post_rst_lo",   lo,        32'd12);
        chk("post_rst_hi",   hi,        32'd0);
        chk("post_rst_busy", 32'(bc),   32'd33);
        chk("post_rst_done", 32'(dc),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_muldiv_unit

`default_nettype wire
